// File: rtl/vga_drawrect_pkg.sv
// Shared constants, register field layout and the rectangle descriptor
// used by the vga_drawrect pixel pipeline.
package vga_drawrect_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int CNT_W = 10;
    localparam int RGB_W = 12;

    localparam int X0_LSB  = 0;
    localparam int Y0_LSB  = 16;
    localparam int W_LSB   = 0;
    localparam int H_LSB   = 16;
    localparam int COL_LSB = 0;
    localparam int EN_BIT  = 0;
    localparam int BG_LSB  = 16;

    typedef struct packed {
        logic [CNT_W-1:0] x0;
        logic [CNT_W-1:0] y0;
        logic [CNT_W-1:0] w;
        logic [CNT_W-1:0] h;
        logic [RGB_W-1:0] colour;
        logic [RGB_W-1:0] bg;
        logic             en;
    } rect_t;

    // lo <= pos < lo+len, evaluated one bit wider so lo+len never wraps.
    function automatic logic in_span(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] len);
        logic [CNT_W:0] hi;
        hi = {1'b0, lo} + {1'b0, len};
        return (pos >= lo) && ({1'b0, pos} < hi);
    endfunction

endpackage

// File: rtl/vga_rect_core_if.sv
// Register inputs and VGA pin outputs of the rectangle renderer.
interface vga_rect_core_if #(
    parameter int COLOR_W = 12
);
    localparam int CH_W = COLOR_W / 3;

    logic [31:0]     slv_reg0;
    logic [31:0]     slv_reg1;
    logic [31:0]     slv_reg2;
    logic [31:0]     slv_reg3;
    logic            vga_hs;
    logic            vga_vs;
    logic [CH_W-1:0] vga_r;
    logic [CH_W-1:0] vga_g;
    logic [CH_W-1:0] vga_b;
    logic            frame_start;

    modport master (
        output slv_reg0, slv_reg1, slv_reg2, slv_reg3,
        input  vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start
    );

    modport slave (
        input  slv_reg0, slv_reg1, slv_reg2, slv_reg3,
        output vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel tick divider, h/v counters and the first pipeline stage
// (registered counters, raw syncs, active and start-of-frame flags).
module vga_timing_gen
    import vga_drawrect_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FRONT  = H_FP,
    parameter int H_SYNC_W = H_SYNC,
    parameter int H_BACK   = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FRONT  = V_FP,
    parameter int V_SYNC_W = V_SYNC,
    parameter int V_BACK   = V_BP
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    output logic             pix_ce,
    output logic             latch_ce,
    output logic [CNT_W-1:0] h_s1,
    output logic [CNT_W-1:0] v_s1,
    output logic             hs_s1,
    output logic             vs_s1,
    output logic             active_s1,
    output logic             sof_s1
);
    localparam int H_TOT = H_ACT + H_FRONT + H_SYNC_W + H_BACK;
    localparam int V_TOT = V_ACT + V_FRONT + V_SYNC_W + V_BACK;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACT - 1);
    localparam logic [CNT_W-1:0] H_SYNC_ON  = CNT_W'(H_ACT + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_OFF = CNT_W'(H_ACT + H_FRONT + H_SYNC_W);
    localparam logic [CNT_W-1:0] V_SYNC_ON  = CNT_W'(V_ACT + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_OFF = CNT_W'(V_ACT + V_FRONT + V_SYNC_W);

    logic [DIV_W-1:0] div_reg, div_next;
    logic [CNT_W-1:0] hcnt_reg, hcnt_next;
    logic [CNT_W-1:0] vcnt_reg, vcnt_next;
    logic [CNT_W-1:0] h_s1_reg, v_s1_reg;
    logic             hs_s1_reg, vs_s1_reg, active_s1_reg, sof_s1_reg;

    assign pix_ce   = (div_reg == DIV_LAST);
    assign latch_ce = pix_ce && (hcnt_reg == H_LAST) && (vcnt_reg == V_ACT_LAST);

    always_comb begin
        div_next  = pix_ce ? '0 : div_reg + 1'b1;
        hcnt_next = hcnt_reg;
        vcnt_next = vcnt_reg;
        if (pix_ce) begin
            if (hcnt_reg == H_LAST) begin
                hcnt_next = '0;
                vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
            end else begin
                hcnt_next = hcnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            div_reg       <= '0;
            hcnt_reg      <= '0;
            vcnt_reg      <= '0;
            h_s1_reg      <= '0;
            v_s1_reg      <= '0;
            hs_s1_reg     <= 1'b1;
            vs_s1_reg     <= 1'b1;
            active_s1_reg <= 1'b0;
            sof_s1_reg    <= 1'b0;
        end else begin
            div_reg  <= div_next;
            hcnt_reg <= hcnt_next;
            vcnt_reg <= vcnt_next;
            if (pix_ce) begin
                h_s1_reg      <= hcnt_reg;
                v_s1_reg      <= vcnt_reg;
                hs_s1_reg     <= !((hcnt_reg >= H_SYNC_ON) && (hcnt_reg < H_SYNC_OFF));
                vs_s1_reg     <= !((vcnt_reg >= V_SYNC_ON) && (vcnt_reg < V_SYNC_OFF));
                active_s1_reg <= (hcnt_reg < H_ACT_END) && (vcnt_reg < V_ACT_END);
                sof_s1_reg    <= (hcnt_reg == '0) && (vcnt_reg == '0);
            end
        end
    end

    assign h_s1      = h_s1_reg;
    assign v_s1      = v_s1_reg;
    assign hs_s1     = hs_s1_reg;
    assign vs_s1     = vs_s1_reg;
    assign active_s1 = active_s1_reg;
    assign sof_s1    = sof_s1_reg;

endmodule

// File: rtl/vga_rect_core.sv
// Renders one filled rectangle over a solid background; register values
// are shadowed at the end of the last active line so a frame never tears.
module vga_rect_core
    import vga_drawrect_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int COLOR_W  = RGB_W,
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FRONT  = H_FP,
    parameter int H_SYNC_W = H_SYNC,
    parameter int H_BACK   = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FRONT  = V_FP,
    parameter int V_SYNC_W = V_SYNC,
    parameter int V_BACK   = V_BP
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    vga_rect_core_if.slave bus
);
    localparam int CH_W = COLOR_W / 3;

    logic             pix_ce, latch_ce;
    logic [CNT_W-1:0] h_s1, v_s1;
    logic             hs_s1, vs_s1, active_s1, sof_s1;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACT   (H_ACT),
        .H_FRONT (H_FRONT),
        .H_SYNC_W(H_SYNC_W),
        .H_BACK  (H_BACK),
        .V_ACT   (V_ACT),
        .V_FRONT (V_FRONT),
        .V_SYNC_W(V_SYNC_W),
        .V_BACK  (V_BACK)
    ) u_timing (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .pix_ce   (pix_ce),
        .latch_ce (latch_ce),
        .h_s1     (h_s1),
        .v_s1     (v_s1),
        .hs_s1    (hs_s1),
        .vs_s1    (vs_s1),
        .active_s1(active_s1),
        .sof_s1   (sof_s1)
    );

    rect_t            regs_now;
    rect_t            shadow_reg;
    logic             hit;
    logic [COLOR_W-1:0] rgb_next, rgb_reg;
    logic             hs_reg, vs_reg, fs_reg;
    logic             unused_bits;

    always_comb begin
        regs_now        = '0;
        regs_now.x0     = bus.slv_reg0[X0_LSB +: CNT_W];
        regs_now.y0     = bus.slv_reg0[Y0_LSB +: CNT_W];
        regs_now.w      = bus.slv_reg1[W_LSB +: CNT_W];
        regs_now.h      = bus.slv_reg1[H_LSB +: CNT_W];
        regs_now.colour = bus.slv_reg2[COL_LSB +: RGB_W];
        regs_now.bg     = bus.slv_reg3[BG_LSB +: RGB_W];
        regs_now.en     = bus.slv_reg3[EN_BIT];
    end

    assign unused_bits = ^{bus.slv_reg0[31:26], bus.slv_reg0[15:10],
                           bus.slv_reg1[31:26], bus.slv_reg1[15:10],
                           bus.slv_reg2[31:12], bus.slv_reg3[31:28],
                           bus.slv_reg3[15:1]};

    // Clipping at the right/bottom edge falls out of the active test.
    always_comb begin
        hit      = shadow_reg.en
                && in_span(h_s1, shadow_reg.x0, shadow_reg.w)
                && in_span(v_s1, shadow_reg.y0, shadow_reg.h);
        rgb_next = '0;
        if (active_s1) begin
            rgb_next = hit ? COLOR_W'(shadow_reg.colour) : COLOR_W'(shadow_reg.bg);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            shadow_reg <= '0;
            hs_reg     <= 1'b1;
            vs_reg     <= 1'b1;
            rgb_reg    <= '0;
            fs_reg     <= 1'b0;
        end else begin
            if (latch_ce) begin
                shadow_reg <= regs_now;
            end
            fs_reg <= pix_ce && sof_s1;
            if (pix_ce) begin
                hs_reg  <= hs_s1;
                vs_reg  <= vs_s1;
                rgb_reg <= rgb_next;
            end
        end
    end

    assign bus.vga_hs      = hs_reg;
    assign bus.vga_vs      = vs_reg;
    assign bus.vga_r       = rgb_reg[2*CH_W +: CH_W];
    assign bus.vga_g       = rgb_reg[CH_W +: CH_W];
    assign bus.vga_b       = rgb_reg[0 +: CH_W];
    assign bus.frame_start = fs_reg;

endmodule
